// File: rtl/fifo1_beat_reader_pkg.sv
// Shared widths, beat geometry and state encoding for the 384-bit entry beat reader.
package fifo1_beat_reader_pkg;

  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned ENTRY_W = 384;
  localparam int unsigned BEATS   = 6;
  localparam int unsigned FIELD_W = 192;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned IDX_W   = 3;

  // Index of the final beat of an entry.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  // Index values past the last beat cannot occur; any decode treats them as idle.
  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return idx <= LAST_IDX;
  endfunction

  // Beat mux, low word first; unreachable index values select zero.
  function automatic logic [BEAT_W-1:0] beat_sel(input logic [ENTRY_W-1:0] entry,
                                                 input logic [IDX_W-1:0]   idx);
    logic [BEAT_W-1:0] word;
    word = '0;
    case (idx)
      3'd0:    word = entry[0*BEAT_W +: BEAT_W];
      3'd1:    word = entry[1*BEAT_W +: BEAT_W];
      3'd2:    word = entry[2*BEAT_W +: BEAT_W];
      3'd3:    word = entry[3*BEAT_W +: BEAT_W];
      3'd4:    word = entry[4*BEAT_W +: BEAT_W];
      3'd5:    word = entry[5*BEAT_W +: BEAT_W];
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/fifo1_beat_reader.sv
// Drains 384-bit entries from a 1-entry upstream FIFO and presents each as six 64-bit beats.
// The entry is latched on dequeue, so beats never depend combinationally on src_first.
module fifo1_beat_reader
  import fifo1_beat_reader_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic [ENTRY_W-1:0] src_first,
  input  logic               src_first__RDY,
  input  logic               src_deq__RDY,
  output logic               src_deq__ENA,
  output logic [BEAT_W-1:0]  beat_v,
  output logic               beat_last,
  output logic               beat__RDY,
  input  logic               beat__ENA,
  output logic [CNT_W-1:0]   msg_count
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ENTRY_W-1:0] hold_q;
  logic [CNT_W-1:0]   cnt_q;

  logic sending;
  logic beat_acc;
  logic last_acc;
  logic load;

  // Handshake decode; a load is allowed only when nothing is held or the last beat leaves now.
  always_comb begin
    sending  = (state_q == StSend) && idx_valid(idx_q);
    beat_acc = nRST && sending && beat__ENA;
    last_acc = beat_acc && (idx_q == LAST_IDX);
    load     = nRST && (!sending || last_acc) && src_deq__RDY && src_first__RDY;
  end

  // Output drive; everything reads as zero while reset is asserted.
  always_comb begin
    src_deq__ENA = load;
    beat__RDY    = nRST && sending;
    beat_last    = nRST && sending && (idx_q == LAST_IDX);
    beat_v       = nRST ? beat_sel(hold_q, idx_q) : '0;
    msg_count    = nRST ? cnt_q : '0;
  end

  // Entry FSM: capture on dequeue, step the beat index on acceptance, reload without a bubble.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else if (load) begin
      hold_q  <= src_first;
      idx_q   <= '0;
      state_q <= StSend;
    end else if (last_acc || !sending) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else if (beat_acc) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Completed-entry counter, wraps naturally at the top of its range.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (last_acc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo1_beat_reader.sv
// Directed bench for fifo1_beat_reader: single entry, back-to-back, backpressure,
// spurious enable, mid-message reset and counter wrap.
module tb_fifo1_beat_reader;
  import fifo1_beat_reader_pkg::*;

  logic               CLK;
  logic               nRST;
  logic [ENTRY_W-1:0] src_first;
  logic               src_first__RDY;
  logic               src_deq__RDY;
  logic               src_deq__ENA;
  logic [BEAT_W-1:0]  beat_v;
  logic               beat_last;
  logic               beat__RDY;
  logic               beat__ENA;
  logic [CNT_W-1:0]   msg_count;

  int vectors;
  int miscompares;

  fifo1_beat_reader dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .src_first      (src_first),
    .src_first__RDY (src_first__RDY),
    .src_deq__RDY   (src_deq__RDY),
    .src_deq__ENA   (src_deq__ENA),
    .beat_v         (beat_v),
    .beat_last      (beat_last),
    .beat__RDY      (beat__RDY),
    .beat__ENA      (beat__ENA),
    .msg_count      (msg_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat j of entry k carries k in the top byte and j in the bottom byte.
  function automatic logic [ENTRY_W-1:0] mk(input int k);
    logic [ENTRY_W-1:0] e;
    logic [FIELD_W-1:0] fa;
    logic [FIELD_W-1:0] fb;
    for (int j = 0; j < 3; j++) begin
      fa[j*BEAT_W +: BEAT_W] = {8'(k), 48'h0, 8'(j)};
      fb[j*BEAT_W +: BEAT_W] = {8'(k), 48'h0, 8'(j + 3)};
    end
    e = {fb, fa};
    return e;
  endfunction

  // Offer one entry from an idle reader and expect the dequeue strobe.
  task automatic load_entry(input logic [ENTRY_W-1:0] ent, input string tag);
    @(negedge CLK);
    src_first      = ent;
    src_first__RDY = 1'b1;
    src_deq__RDY   = 1'b1;
    beat__ENA      = 1'b1;
    #1;
    chk({tag, " deq"}, 64'(src_deq__ENA), 64'd1);
    chk({tag, " rdy_before"}, 64'(beat__RDY), 64'd0);
  endtask

  // Accept beats 0..n-1 with upstream empty; optional 4-cycle stall before beat stall_at.
  task automatic run_beats(input logic [ENTRY_W-1:0] ent, input int stall_at, input int n,
                           input string tag);
    for (int j = 0; j < n; j++) begin
      if (j == stall_at) begin
        for (int s = 0; s < 4; s++) begin
          @(negedge CLK);
          beat__ENA      = 1'b0;
          src_first__RDY = 1'b1;
          src_deq__RDY   = 1'b1;
          #1;
          chk({tag, " stall_v"}, beat_v, ent[j*BEAT_W +: BEAT_W]);
          chk({tag, " stall_deq"}, 64'(src_deq__ENA), 64'd0);
          chk({tag, " stall_rdy"}, 64'(beat__RDY), 64'd1);
        end
      end
      @(negedge CLK);
      src_first__RDY = 1'b0;
      beat__ENA      = 1'b1;
      #1;
      chk({tag, " v"}, beat_v, ent[j*BEAT_W +: BEAT_W]);
      chk({tag, " last"}, 64'(beat_last), 64'(j == 5));
      chk({tag, " rdy"}, 64'(beat__RDY), 64'd1);
      chk({tag, " deq"}, 64'(src_deq__ENA), 64'd0);
    end
  endtask

  task automatic chk_idle(input logic [15:0] cnt, input string tag);
    @(negedge CLK);
    src_first__RDY = 1'b0;
    #1;
    chk({tag, " idle_rdy"}, 64'(beat__RDY), 64'd0);
    chk({tag, " idle_last"}, 64'(beat_last), 64'd0);
    chk({tag, " count"}, 64'(msg_count), 64'(cnt));
  endtask

  initial begin
    logic [ENTRY_W-1:0] ab;
    logic [ENTRY_W-1:0] ent;
    vectors        = 0;
    miscompares    = 0;
    nRST           = 1'b0;
    src_first      = {ENTRY_W{1'b1}};
    src_first__RDY = 1'b1;
    src_deq__RDY   = 1'b1;
    beat__ENA      = 1'b1;

    // Reset: outputs gated low even with upstream offering data.
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst rdy", 64'(beat__RDY), 64'd0);
    chk("rst last", 64'(beat_last), 64'd0);
    chk("rst v", beat_v, 64'd0);
    chk("rst count", 64'(msg_count), 64'd0);
    chk("rst deq", 64'(src_deq__ENA), 64'd0);
    src_first__RDY = 1'b0;
    nRST           = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_rst rdy", 64'(beat__RDY), 64'd0);

    // Single entry: A words then B words.
    ab = {{3{64'hBBBB_BBBB_BBBB_BBBB}}, {3{64'hAAAA_AAAA_AAAA_AAAA}}};
    load_entry(ab, "single");
    run_beats(ab, -1, 6, "single");
    chk_idle(16'd1, "single");

    // Back-to-back: three entries, upstream refilled immediately.
    load_entry(mk(0), "b2b");
    for (int m = 0; m < 3; m++) begin
      for (int j = 0; j < 6; j++) begin
        @(negedge CLK);
        src_first      = mk(m + 1);
        src_first__RDY = (m < 2);
        src_deq__RDY   = 1'b1;
        beat__ENA      = 1'b1;
        #1;
        ent = mk(m);
        chk("b2b v", beat_v, ent[j*BEAT_W +: BEAT_W]);
        chk("b2b last", 64'(beat_last), 64'(j == 5));
        chk("b2b rdy", 64'(beat__RDY), 64'd1);
        chk("b2b deq", 64'(src_deq__ENA), 64'((j == 5) && (m < 2)));
      end
    end
    chk_idle(16'd4, "b2b");

    // Backpressure at beat 2 with upstream ready: no overwrite, resume at beat 2.
    load_entry(mk(3), "bp");
    run_beats(mk(3), 2, 6, "bp");
    chk_idle(16'd5, "bp");

    // Spurious enable while idle.
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK);
      src_first__RDY = 1'b0;
      src_deq__RDY   = 1'b1;
      beat__ENA      = 1'b1;
      #1;
      chk("spur rdy", 64'(beat__RDY), 64'd0);
      chk("spur deq", 64'(src_deq__ENA), 64'd0);
      chk("spur count", 64'(msg_count), 64'd5);
    end

    // Reset at beat 3: held entry dropped, next beats from a fresh entry.
    load_entry(mk(4), "mrst");
    run_beats(mk(4), -1, 3, "mrst");
    @(negedge CLK);
    #1;
    ent = mk(4);
    chk("mrst pre_v", beat_v, ent[3*BEAT_W +: BEAT_W]);
    nRST = 1'b0;
    #1;
    chk("mrst in_rdy", 64'(beat__RDY), 64'd0);
    chk("mrst in_v", beat_v, 64'd0);
    chk("mrst in_count", 64'(msg_count), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("mrst out_rdy", 64'(beat__RDY), 64'd0);
    chk("mrst out_v", beat_v, 64'd0);
    chk("mrst out_count", 64'(msg_count), 64'd0);
    load_entry(mk(5), "fresh");
    run_beats(mk(5), -1, 6, "fresh");
    chk_idle(16'd1, "fresh");

    // Counter wrap from 0xFFFF.
    @(negedge CLK);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap pre", 64'(msg_count), 64'hFFFF);
    load_entry(mk(6), "wrap");
    run_beats(mk(6), -1, 6, "wrap");
    chk_idle(16'h0000, "wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
